// File: rtl/ili9341_pkg.sv
// ----------------------------------------------------------------------------
// ili9341_pkg
// Shared definitions for the ILI9341 SPI driver: panel command opcodes,
// the FSM state type and the byte tables for the power-up and window
// sequences.
// Contents:
//   CMD_*          8-bit command opcodes
//   waitSel_e      which post-command idle delay (if any) follows a byte
//   romEntry_t     {dc, data, waitSel} entry of a byte table
//   drvState_e     top-level FSM state encoding
//   initEntry()    power-up byte table
//   windowEntry()  CASET/PASET/RAMWR byte table for a given window size
// ----------------------------------------------------------------------------
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // COLMOD 0x55 selects 16 bpp RGB565; MADCTL 0x48 = column order + BGR
  localparam logic [7:0] PARAM_COLMOD = 8'h55;
  localparam logic [7:0] PARAM_MADCTL = 8'h48;

  localparam int INIT_LEN   = 7;
  localparam int WINDOW_LEN = 11;

  typedef enum logic [1:0] {
    WAIT_NONE,
    WAIT_RESET,
    WAIT_SLEEP
  } waitSel_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    waitSel_e   waitSel;
  } romEntry_t;

  typedef enum logic [2:0] {
    INIT_CMD,
    INIT_WAIT,
    WINDOW,
    STREAM,
    FRAME_WAIT
  } drvState_e;

  // Power-up sequence, one byte per index
  function automatic romEntry_t initEntry(input logic [3:0] idx);
    romEntry_t e;
    case (idx)
      4'd0:    e = '{1'b0, CMD_SWRESET,  WAIT_RESET};
      4'd1:    e = '{1'b0, CMD_SLPOUT,   WAIT_SLEEP};
      4'd2:    e = '{1'b0, CMD_COLMOD,   WAIT_NONE};
      4'd3:    e = '{1'b1, PARAM_COLMOD, WAIT_NONE};
      4'd4:    e = '{1'b0, CMD_MADCTL,   WAIT_NONE};
      4'd5:    e = '{1'b1, PARAM_MADCTL, WAIT_NONE};
      default: e = '{1'b0, CMD_DISPON,   WAIT_NONE};
    endcase
    return e;
  endfunction

  // Window setup: start addresses are always 0, end addresses are inclusive
  function automatic romEntry_t windowEntry(input logic [3:0]  idx,
                                            input logic [15:0] colEnd,
                                            input logic [15:0] rowEnd);
    romEntry_t e;
    case (idx)
      4'd0:    e = '{1'b0, CMD_CASET,     WAIT_NONE};
      4'd1:    e = '{1'b1, 8'h00,         WAIT_NONE};
      4'd2:    e = '{1'b1, 8'h00,         WAIT_NONE};
      4'd3:    e = '{1'b1, colEnd[15:8],  WAIT_NONE};
      4'd4:    e = '{1'b1, colEnd[7:0],   WAIT_NONE};
      4'd5:    e = '{1'b0, CMD_PASET,     WAIT_NONE};
      4'd6:    e = '{1'b1, 8'h00,         WAIT_NONE};
      4'd7:    e = '{1'b1, 8'h00,         WAIT_NONE};
      4'd8:    e = '{1'b1, rowEnd[15:8],  WAIT_NONE};
      4'd9:    e = '{1'b1, rowEnd[7:0],   WAIT_NONE};
      default: e = '{1'b0, CMD_RAMWR,     WAIT_NONE};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ili9341_spi_driver_if.sv
// ----------------------------------------------------------------------------
// ili9341_spi_driver_if
// Bundles the pixel-source handshake and the panel pins of the driver.
//   frame_done  upstream -> driver  no more pixels in the current frame
//   input_data  upstream -> driver  RGB565 pixel
//   data_clk    driver -> upstream  free-running pixel strobe
//   spi_mosi    driver -> panel     serial data, MSB first
//   spi_sck     driver -> panel     SPI clock, mode 0
//   spi_cs      driver -> panel     chip select, active low
//   spi_dc      driver -> panel     0 = command, 1 = data
// Modports: master = driver side, slave = upstream/panel side.
// ----------------------------------------------------------------------------
interface ili9341_spi_driver_if;
  logic        frame_done;
  logic [15:0] input_data;
  logic        data_clk;
  logic        spi_mosi;
  logic        spi_sck;
  logic        spi_cs;
  logic        spi_dc;

  modport master (
    input  frame_done, input_data,
    output data_clk, spi_mosi, spi_sck, spi_cs, spi_dc
  );

  modport slave (
    output frame_done, input_data,
    input  data_clk, spi_mosi, spi_sck, spi_cs, spi_dc
  );
endinterface

// File: rtl/ili9341_spi_shifter.sv
// ----------------------------------------------------------------------------
// ili9341_spi_shifter
// Serialises one {dc, byte} at clk/2, SPI mode 0, MSB first. Each bit spends
// one cycle with SCK low (data settles) and one with SCK high (panel samples).
// A new byte may be loaded in the cycle done_o is high, so consecutive bytes
// run back to back at exactly 16 cycles per byte.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load_i     start a byte (accepted when idle or in the done cycle)
//   dc_i       D/C level to present for this byte
//   data_i     byte to send
//   mosi_o     serial data (0 while idle)
//   sck_o      SPI clock (idles low)
//   dc_o       D/C level of the byte in flight / last byte
//   busy_o     byte in progress
//   done_o     high during the final SCK-high cycle of a byte
// ----------------------------------------------------------------------------
module ili9341_spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       dc_i,
  input  logic [7:0] data_i,
  output logic       mosi_o,
  output logic       sck_o,
  output logic       dc_o,
  output logic       busy_o,
  output logic       done_o
);

  logic       active_q, active_d;
  logic       phase_q,  phase_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q,  shift_d;
  logic       dc_q,     dc_d;
  logic       lastCycle;

  assign lastCycle = active_q & phase_q & (bitCnt_q == 3'd7);

  // Bit sequencing: the shift register advances on the high-to-low SCK
  // transition so MOSI changes only while SCK is low. A load overrides
  // everything so the next byte starts right after the last SCK-high cycle.
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    dc_d     = dc_q;
    if (active_q) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        if (bitCnt_q == 3'd7) begin
          active_d = 1'b0;
        end else begin
          bitCnt_d = bitCnt_q + 3'd1;
          shift_d  = {shift_q[6:0], 1'b0};
        end
      end
    end
    if (load_i && (!active_q || lastCycle)) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      bitCnt_d = 3'd0;
      shift_d  = data_i;
      dc_d     = dc_i;
    end
  end

  // State register; reset abandons any byte in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      bitCnt_q <= 3'd0;
      shift_q  <= 8'd0;
      dc_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      dc_q     <= dc_d;
    end
  end

  assign sck_o  = active_q & phase_q;
  assign mosi_o = active_q & shift_q[7];
  assign dc_o   = dc_q;
  assign busy_o = active_q;
  assign done_o = lastCycle;

endmodule

// File: rtl/ili9341_spi_driver.sv
// ----------------------------------------------------------------------------
// ili9341_spi_driver
// Brings up an ILI9341 panel over write-only 4-wire SPI, opens a WIDTH x HEIGHT
// window, then streams RGB565 pixels paced by a 32-cycle pixel strobe.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       ili9341_spi_driver_if.master: frame_done, input_data in;
//             spi_mosi, spi_sck, spi_cs, spi_dc, data_clk out
// Parameters:
//   WIDTH, HEIGHT           window size in pixels
//   RESET_WAIT, SLEEP_WAIT  idle clk cycles after SWRESET / SLPOUT
// ----------------------------------------------------------------------------
module ili9341_spi_driver
  import ili9341_pkg::*;
#(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 240,
  parameter int RESET_WAIT = 7500000,
  parameter int SLEEP_WAIT = 7500000
) (
  input  logic                   clk,
  input  logic                   rst,
  ili9341_spi_driver_if.master   bus
);

  localparam logic [15:0] COL_END = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_END = 16'(HEIGHT - 1);

  drvState_e   state_q,  state_d;
  logic [3:0]  idx_q,    idx_d;
  logic [31:0] waitCnt_q, waitCnt_d;
  logic        cs_q,     cs_d;
  logic [1:0]  gapCnt_q, gapCnt_d;
  logic [4:0]  phase_q,  phase_d;
  logic [7:0]  pixLo_q,  pixLo_d;
  logic        loHalf_q, loHalf_d;

  logic        shLoad, shDc, shBusy, shDone, canLoad, boundary;
  logic [7:0]  shData;
  romEntry_t   entry;

  // The shifter can take a byte when idle or in its final cycle
  assign canLoad = !shBusy || shDone;
  // data_clk is phase_q[4]; the 15->16 step is its rising edge, so a load
  // issued here is latched on that same clock edge
  assign boundary = (phase_q == 5'd15);
  assign entry = (state_q == WINDOW) ? windowEntry(idx_q, COL_END, ROW_END)
                                     : initEntry(idx_q);

  // Next-state logic. Commands need CS to have been high for at least two
  // cycles, so a command byte first raises CS, then waits for gapCnt to
  // saturate before dropping CS and loading. Parameter bytes go straight out.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    waitCnt_d = waitCnt_q;
    cs_d      = cs_q;
    pixLo_d   = pixLo_q;
    loHalf_d  = loHalf_q;
    phase_d   = phase_q + 5'd1;
    gapCnt_d  = cs_q ? ((gapCnt_q == 2'd2) ? 2'd2 : gapCnt_q + 2'd1) : 2'd0;
    shLoad    = 1'b0;
    shDc      = 1'b0;
    shData    = 8'd0;

    case (state_q)
      INIT_CMD, WINDOW: begin
        if (canLoad) begin
          if (entry.dc || (cs_q && gapCnt_q == 2'd2)) begin
            shLoad = 1'b1;
            shDc   = entry.dc;
            shData = entry.data;
            cs_d   = 1'b0;
            idx_d  = idx_q + 4'd1;
            if (state_q == INIT_CMD) begin
              if (entry.waitSel != WAIT_NONE) begin
                state_d   = INIT_WAIT;
                waitCnt_d = (entry.waitSel == WAIT_RESET) ? 32'(RESET_WAIT)
                                                          : 32'(SLEEP_WAIT);
              end else if (idx_q == 4'(INIT_LEN - 1)) begin
                state_d = WINDOW;
                idx_d   = 4'd0;
              end
            end else if (idx_q == 4'(WINDOW_LEN - 1)) begin
              state_d  = STREAM;
              loHalf_d = 1'b0;
            end
          end else if (!entry.dc && !cs_q) begin
            cs_d = 1'b1;
          end
        end
      end

      INIT_WAIT: begin
        if (shDone) begin
          cs_d = 1'b1;
        end
        if (!shBusy) begin
          if (waitCnt_q == 32'd0) begin
            state_d = INIT_CMD;
          end else begin
            waitCnt_d = waitCnt_q - 32'd1;
          end
        end
      end

      STREAM: begin
        if (loHalf_q && shDone) begin
          shLoad   = 1'b1;
          shDc     = 1'b1;
          shData   = pixLo_q;
          loHalf_d = 1'b0;
        end else if (boundary && canLoad) begin
          if (bus.frame_done) begin
            cs_d    = 1'b1;
            state_d = FRAME_WAIT;
          end else begin
            shLoad   = 1'b1;
            shDc     = 1'b1;
            shData   = bus.input_data[15:8];
            pixLo_d  = bus.input_data[7:0];
            loHalf_d = 1'b1;
          end
        end
      end

      FRAME_WAIT: begin
        cs_d = 1'b1;
        if (boundary && !bus.frame_done) begin
          state_d = WINDOW;
          idx_d   = 4'd0;
        end
      end

      default: state_d = INIT_CMD;
    endcase
  end

  // State register; reset restarts the whole power-up sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT_CMD;
      idx_q     <= 4'd0;
      waitCnt_q <= 32'd0;
      cs_q      <= 1'b1;
      gapCnt_q  <= 2'd0;
      phase_q   <= 5'd0;
      pixLo_q   <= 8'd0;
      loHalf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      waitCnt_q <= waitCnt_d;
      cs_q      <= cs_d;
      gapCnt_q  <= gapCnt_d;
      phase_q   <= phase_d;
      pixLo_q   <= pixLo_d;
      loHalf_q  <= loHalf_d;
    end
  end

  ili9341_spi_shifter u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load_i (shLoad),
    .dc_i   (shDc),
    .data_i (shData),
    .mosi_o (bus.spi_mosi),
    .sck_o  (bus.spi_sck),
    .dc_o   (bus.spi_dc),
    .busy_o (shBusy),
    .done_o (shDone)
  );

  assign bus.spi_cs   = cs_q;
  assign bus.data_clk = phase_q[4];

endmodule

// File: tb/tb_ili9341_spi_driver.sv
// ----------------------------------------------------------------------------
// tb_ili9341_spi_driver
// Directed bench for ili9341_spi_driver with short power-up waits. A mode-0
// monitor decodes {dc, byte} from the SPI pins and the main sequence compares
// the decoded stream and the pin levels against hand-written expectations.
// ----------------------------------------------------------------------------
module tb_ili9341_spi_driver;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  ili9341_spi_driver_if bus ();

  ili9341_spi_driver #(
    .WIDTH      (240),
    .HEIGHT     (240),
    .RESET_WAIT (10),
    .SLEEP_WAIT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp decoded bytes
  always @(posedge clk) cycle <= cycle + 1;

  // Mode-0 monitor: sample MOSI/DC on each SCK rise while CS is low and
  // collect complete bytes; cleared whenever reset is asserted
  logic [8:0] byteQ[$];
  int         startQ[$];
  int         endQ[$];
  int         sckEdges = 0;
  logic       prevSck  = 1'b0;
  logic [7:0] monShift;
  int         monBits  = 0;
  int         monStart = 0;

  always @(negedge clk) begin
    if (rst) begin
      byteQ.delete();
      startQ.delete();
      endQ.delete();
      monBits = 0;
    end else begin
      if (bus.spi_cs) monBits = 0;
      if (bus.spi_sck && !prevSck) begin
        sckEdges++;
        if (!bus.spi_cs) begin
          if (monBits == 0) monStart = cycle;
          monShift = {monShift[6:0], bus.spi_mosi};
          monBits++;
          if (monBits == 8) begin
            byteQ.push_back({bus.spi_dc, monShift});
            startQ.push_back(monStart);
            endQ.push_back(cycle);
            monBits = 0;
          end
        end
      end
    end
    prevSck = bus.spi_sck;
  end

  localparam logic [8:0] EXP_INIT [24] = '{
    9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029,
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C,
    9'h1F8, 9'h100, 9'h107, 9'h1E0, 9'h100, 9'h11F
  };

  localparam logic [8:0] EXP_RESTART [13] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C,
    9'h107, 9'h1E0
  };

  localparam logic [15:0] NEXT_PIX [3] = '{16'h07E0, 16'h001F, 16'h001F};

  function automatic logic [8:0] byteAt(input int i);
    if (i < byteQ.size()) return byteQ[i];
    return 9'h1FF;
  endfunction

  task automatic applyStimulus(input logic r, input logic fd, input logic [15:0] px);
    rst            = r;
    bus.frame_done = fd;
    bus.input_data = px;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetPins(input string tag);
    checkOutput({tag, "_cs"},      32'(bus.spi_cs),   32'd1);
    checkOutput({tag, "_sck"},     32'(bus.spi_sck),  32'd0);
    checkOutput({tag, "_mosi"},    32'(bus.spi_mosi), 32'd0);
    checkOutput({tag, "_dc"},      32'(bus.spi_dc),   32'd0);
    checkOutput({tag, "_dataclk"}, 32'(bus.data_clk), 32'd0);
  endtask

  task automatic waitBytes(input string tag, input int n, input int maxCycles);
    for (int i = 0; i < maxCycles && byteQ.size() < n; i++) @(negedge clk);
    checkOutput(tag, 32'(byteQ.size() >= n), 32'd1);
  endtask

  task automatic waitDataClk(input logic level, input int maxCycles, output int cyc);
    logic prev;
    prev = bus.data_clk;
    cyc  = -1;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (bus.data_clk == level && prev != level) begin
        cyc = cycle;
        break;
      end
      prev = bus.data_clk;
    end
  endtask

  // A pixel was latched on a data_clk rise if a data byte starts right then
  task automatic waitPixelLatch(input string tag, input int maxCycles);
    logic prev;
    logic ok;
    prev = bus.data_clk;
    ok   = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (bus.data_clk && !prev && !bus.spi_cs && bus.spi_dc) begin
        ok = 1'b1;
        break;
      end
      prev = bus.data_clk;
    end
    checkOutput(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int c1, c2, c3, e0;

    // Reset values
    applyStimulus(1'b1, 1'b0, 16'hF800);
    repeat (5) @(negedge clk);
    checkResetPins("reset");

    // data_clk period and duty after release
    applyStimulus(1'b0, 1'b0, 16'hF800);
    waitDataClk(1'b1, 64, c1);
    waitDataClk(1'b0, 64, c2);
    waitDataClk(1'b1, 64, c3);
    checkOutput("dataclk_high", 32'(c2 - c1), 32'd16);
    checkOutput("dataclk_period", 32'(c3 - c1), 32'd32);

    // Power-up and window bytes
    waitBytes("init_bytes_timeout", 18, 4000);
    for (int i = 0; i < 18; i++)
      checkOutput($sformatf("init_byte%0d", i), 32'(byteAt(i)), 32'(EXP_INIT[i]));
    if (startQ.size() >= 3) begin
      checkOutput("gap_after_swreset", 32'(startQ[1] - endQ[0] >= 12), 32'd1);
      checkOutput("gap_after_slpout",  32'(startQ[2] - endQ[1] >= 12), 32'd1);
    end else begin
      checkOutput("gap_bytes_present", 32'(startQ.size()), 32'd3);
    end

    // Pixel stream: next value presented after each latch
    for (int k = 0; k < 3; k++) begin
      waitPixelLatch($sformatf("pixel_latch%0d", k), 100);
      checkOutput($sformatf("stream_cs%0d", k), 32'(bus.spi_cs), 32'd0);
      bus.input_data = NEXT_PIX[k];
    end

    // Frame end raised mid-pixel: that pixel still completes
    repeat (5) @(negedge clk);
    bus.frame_done = 1'b1;
    waitBytes("stream_bytes_timeout", 24, 200);
    for (int i = 18; i < 24; i++)
      checkOutput($sformatf("pixel_byte%0d", i - 18), 32'(byteAt(i)), 32'(EXP_INIT[i]));
    repeat (40) @(negedge clk);
    e0 = sckEdges;
    repeat (100) @(negedge clk);
    checkOutput("frame_wait_sck", 32'(sckEdges), 32'(e0));
    checkOutput("frame_wait_bytes", 32'(byteQ.size()), 32'd24);
    checkOutput("frame_wait_cs", 32'(bus.spi_cs), 32'd1);

    // Restart: window re-sent, then the stream resumes
    bus.input_data = 16'h07E0;
    bus.frame_done = 1'b0;
    waitBytes("restart_bytes_timeout", 37, 400);
    for (int i = 0; i < 13; i++)
      checkOutput($sformatf("restart_byte%0d", i), 32'(byteAt(24 + i)), 32'(EXP_RESTART[i]));

    // Reset during bit 7 of a pixel byte, then full replay from SWRESET
    waitPixelLatch("pre_reset_latch", 100);
    rst = 1'b1;
    @(negedge clk);
    checkResetPins("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitBytes("replay_bytes_timeout", 3, 1000);
    checkOutput("replay_byte0", 32'(byteAt(0)), 32'h001);
    checkOutput("replay_byte1", 32'(byteAt(1)), 32'h011);
    checkOutput("replay_byte2", 32'(byteAt(2)), 32'h03A);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
